// File: rtl/capture_pkg.sv
// capture_pkg: shared widths and FSM encodings for the capture line FIFO
package capture_pkg;
  localparam int DATA_W = 16;
  localparam int LINE_WORDS = 512;
  localparam int PTR_W = $clog2(LINE_WORDS);
  localparam int LINE_W = 9;
  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DONE} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_PRIME, R_DRAIN} rd_state_t;
endpackage

// File: rtl/line_buf_ram.sv
// line_buf_ram: two-bank line store, one write port, one synchronous read port (bank = address MSB)
module line_buf_ram
  import capture_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [PTR_W:0]    i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [PTR_W:0]    i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] mem [2*LINE_WORDS];
  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
    o_rdata <= mem[i_raddr];
  end
endmodule

// File: rtl/capture_line_fifo.sv
// capture_line_fifo: ping-pong capture of pixel lines into two RAM banks, drained through a show-ahead line FIFO port
module capture_line_fifo
  import capture_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_pix_valid,
  input  logic [DATA_W-1:0] i_pix_data,
  input  logic              i_hsync,
  input  logic              i_vsync,
  output logic              o_fifo_nempty,
  output logic [LINE_W-1:0] o_fifo_line,
  output logic [DATA_W-1:0] o_fifo_data,
  input  logic              i_fifo_next,
  input  logic              i_fifo_reset,
  output logic              o_err
);
  wr_state_t wr_state;
  rd_state_t rd_state;
  logic [1:0] full;
  logic [LINE_W-1:0] tag [2];
  logic [LINE_W-1:0] line_cnt, lc;
  logic wr_bank, rd_bank, fill_b, idle_like, alloc, rel, we, wb;
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nx, wa;
  logic [DATA_W-1:0] ram_q, hold;
  always_comb begin
    idle_like = wr_state != W_FILL || i_vsync;
    lc = i_vsync ? '0 : line_cnt;
    fill_b = full[rd_bank] ? ~rd_bank : rd_bank;
    alloc = i_hsync && (!idle_like || !(&full));
    wb = (i_hsync && idle_like) ? fill_b : wr_bank;
    wa = i_hsync ? '0 : wr_ptr;
    we = i_pix_valid && (alloc || (!i_hsync && !i_vsync && wr_state == W_FILL));
    rel = i_fifo_reset && full[rd_bank];
    rd_ptr_nx = rd_ptr + PTR_W'(o_fifo_nempty && i_fifo_next && !i_fifo_reset);
  end
  line_buf_ram u_ram (
    .i_clk  (i_clk),
    .i_we   (we),
    .i_waddr({wb, wa}),
    .i_wdata(i_pix_data),
    .i_raddr({rd_bank, rd_ptr_nx}),
    .o_rdata(ram_q)
  );
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_state <= W_IDLE;
      full <= '0;
      tag <= '{default: '0};
      line_cnt <= '0;
      wr_bank <= 1'b0;
      wr_ptr <= '0;
      o_err <= 1'b0;
    end else begin
      if (rel) full[rd_bank] <= 1'b0;
      if (i_vsync) begin
        line_cnt <= '0;
        wr_state <= W_IDLE;
      end
      if (i_hsync) begin
        if (!alloc) begin
          o_err <= 1'b1;
          line_cnt <= lc + 1'b1;
          wr_state <= W_IDLE;
        end else if (idle_like) begin
          wr_state <= W_FILL;
          wr_bank <= fill_b;
          tag[fill_b] <= lc;
          wr_ptr <= PTR_W'(i_pix_valid);
        end else begin
          o_err <= 1'b1;
          line_cnt <= line_cnt + 1'b1;
          tag[wr_bank] <= line_cnt + 1'b1;
          wr_ptr <= PTR_W'(i_pix_valid);
        end
      end else if (we) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (&wr_ptr) begin
          full[wr_bank] <= 1'b1;
          line_cnt <= line_cnt + 1'b1;
          wr_state <= W_DONE;
        end
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_state <= R_IDLE;
      rd_bank <= 1'b0;
      rd_ptr <= '0;
      o_fifo_nempty <= 1'b0;
      o_fifo_line <= '0;
      hold <= '0;
    end else begin
      if (o_fifo_nempty) hold <= ram_q;
      if (i_fifo_reset) begin
        rd_state <= R_IDLE;
        rd_ptr <= '0;
        o_fifo_nempty <= 1'b0;
        if (rel) rd_bank <= ~rd_bank;
      end else if (rd_state == R_IDLE) begin
        if (full[rd_bank]) rd_state <= R_PRIME;
      end else if (rd_state == R_PRIME) begin
        rd_state <= R_DRAIN;
        o_fifo_nempty <= 1'b1;
        o_fifo_line <= tag[rd_bank];
      end else begin
        rd_ptr <= rd_ptr_nx;
      end
    end
  end
  assign o_fifo_data = o_fifo_nempty ? ram_q : hold;
endmodule
